// File: rtl/display_pkg.sv
// Shared definitions for the BCD display scanner.
//   conv_state_t : conversion FSM states (IDLE, CONV)
//   BCD_INVALID  : nibble shown on every digit when the value does not fit
//   max_display  : largest value representable with a given digit count
package display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  // 10^digits - 1, evaluated at elaboration time
  function automatic int max_display(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// One combinational double-dabble step: add 3 to every BCD nibble >= 5,
// then shift {scratch, shift register} left by one bit.
//   i_scratch / o_scratch : 4*DIGITS-bit BCD accumulator before/after the step
//   i_shift   / o_shift   : WIDTH-bit binary shift register before/after the step
module bin2bcd_iter #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] i_scratch,
  input  logic [WIDTH-1:0]    i_shift,
  output logic [4*DIGITS-1:0] o_scratch,
  output logic [WIDTH-1:0]    o_shift
);

  logic [4*DIGITS-1:0] w_adj;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
    assign w_adj[gi*4 +: 4] = (i_scratch[gi*4 +: 4] >= 4'd5) ?
                              i_scratch[gi*4 +: 4] + 4'd3 :
                              i_scratch[gi*4 +: 4];
  end

  // The shift keeps the concatenation width, so the scratch MSB falls off;
  // that bit can only be set for values that are flagged as overflow anyway.
  assign {o_scratch, o_shift} = {w_adj, i_shift} << 1;

endmodule

// File: rtl/bcd_display_scanner.sv
// Latches a binary value, converts it to DIGITS BCD digits by iterative
// double-dabble (one bit per clock) and time-multiplexes the committed digits
// onto a single BCD bus with a one-hot digit select.
//   clk, rst  : system clock, synchronous active-high reset
//   value_in  : binary value to display, captured when load is accepted
//   load      : single-cycle convert request, ignored while busy
//   busy      : conversion in progress
//   overflow  : last committed value exceeded 10^DIGITS-1 (digits show F)
//   digit_bcd : BCD nibble of the currently selected digit
//   digit_sel : one-hot digit select, bit 0 = least significant digit
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value_in,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        digit_bcd,
  output logic [DIGITS-1:0] digit_sel
);

  localparam int SW      = 4 * DIGITS;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam int PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAX_VAL = max_display(DIGITS);
  localparam logic [WIDTH+31:0] MAX_EXT = (WIDTH + 32)'(unsigned'(MAX_VAL));

  conv_state_t      r_state;
  logic [CW-1:0]    r_iter;
  logic [SW-1:0]    r_scratch;
  logic [WIDTH-1:0] r_shift;
  logic             r_ovf_pend;
  logic             r_busy;
  logic             r_overflow;
  logic [SW-1:0]    r_disp;
  logic [PW-1:0]    r_presc;
  logic [IW-1:0]    r_idx;
  logic [DIGITS-1:0] r_digit_sel;
  logic [3:0]       r_digit_bcd;

  logic [SW-1:0]    w_scratch_step;
  logic [WIDTH-1:0] w_shift_step;
  logic             w_commit;
  logic [SW-1:0]    w_commit_val;
  logic [SW-1:0]    w_disp_next;
  logic             w_wrap;
  logic [IW-1:0]    w_idx_next;

  bin2bcd_iter #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_iter (
    .i_scratch (r_scratch),
    .i_shift   (r_shift),
    .o_scratch (w_scratch_step),
    .o_shift   (w_shift_step)
  );

  // After WIDTH iterations the scratch holds the result; commit on the next edge.
  assign w_commit     = (r_state == CONV) && (r_iter == CW'(WIDTH));
  assign w_commit_val = r_ovf_pend ? {DIGITS{BCD_INVALID}} : r_scratch;
  // Next-cycle display contents, so a commit is visible on the same edge it lands.
  assign w_disp_next  = w_commit ? w_commit_val : r_disp;

  assign w_wrap     = (r_presc == PW'(SCAN_DIV - 1));
  assign w_idx_next = !w_wrap ? r_idx :
                      (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);

  // Conversion FSM and display registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_iter     <= '0;
      r_scratch  <= '0;
      r_shift    <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_disp     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift    <= value_in;
            r_scratch  <= '0;
            r_iter     <= '0;
            r_ovf_pend <= ({32'd0, value_in} > MAX_EXT);
            r_busy     <= 1'b1;
            r_state    <= CONV;
          end
        end
        CONV: begin
          if (w_commit) begin
            r_disp     <= w_commit_val;
            r_overflow <= r_ovf_pend;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_scratch <= w_scratch_step;
            r_shift   <= w_shift_step;
            r_iter    <= r_iter + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Free-running scanner; outputs registered from next-state values so
  // digit_sel and digit_bcd always change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_digit_sel <= DIGITS'(1);
      r_digit_bcd <= 4'd0;
    end else begin
      r_presc     <= w_wrap ? '0 : r_presc + PW'(1);
      r_idx       <= w_idx_next;
      r_digit_sel <= DIGITS'(1) << w_idx_next;
      r_digit_bcd <= w_disp_next[w_idx_next*4 +: 4];
    end
  end

  assign busy      = r_busy;
  assign overflow  = r_overflow;
  assign digit_bcd = r_digit_bcd;
  assign digit_sel = r_digit_sel;

endmodule
